// File: rtl/rom_rd_arbiter_pkg.sv
// Shared constants and types for the ROM read-port arbiter.
// The tag idx field is sized for the largest supported requester count.
package rom_arb_pkg;

  localparam int unsigned ROM_LAT   = 2;
  localparam int unsigned MAX_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } tag_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_rd_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last-granted one.
// The pointer resets to N-1 so requester 0 wins first.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_ptr;
  int unsigned   w_best_d;
  int unsigned   w_best_k;
  int unsigned   w_d;
  logic          w_hit;

  // Priority distance 0 belongs to the index right after the pointer.
  always_comb begin
    w_best_d = N;
    w_best_k = 0;
    w_d      = 0;
    w_hit    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_req[k]) begin
        w_d = (k + N - 1 - 32'(r_ptr)) % N;
        if (w_d < w_best_d) begin
          w_best_d = w_d;
          w_best_k = k;
          w_hit    = i_rst_n;
        end
      end
    end
    o_gnt = '0;
    for (int unsigned k = 0; k < N; k++) begin
      o_gnt[k] = w_hit && (k == w_best_k);
    end
    o_idx = w_hit ? IW'(w_best_k) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= IW'(N - 1);
    end else if (|o_gnt) begin
      r_ptr <= o_idx;
    end
  end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Shares one 2-stage synchronous ROM read port between N_REQ requesters.
// Each issued read carries a tag through a ROM_LAT-deep pipeline to route the word back.
module rom_rd_arbiter #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ROM_LAT = rom_arb_pkg::ROM_LAT
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic [N_REQ-1:0]        REQ_I,
  input  logic [N_REQ*ADDR_W-1:0] ADDR_I,
  output logic [N_REQ-1:0]        GNT_O,
  output logic [N_REQ-1:0]        RD_VALID_O,
  output logic [DATA_W-1:0]       RD_DATA_O,
  output logic [ADDR_W-1:0]       ROM_ADDR_O,
  output logic                    ROM_CLK_EN_O,
  output logic                    ROM_RST_O,
  input  logic [DATA_W-1:0]       ROM_Q_I
);

  import rom_arb_pkg::*;

  localparam int unsigned IW = idx_w(N_REQ);

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_any_tag;
  logic             w_clk_en;
  tag_t             w_last;
  tag_t             r_tag [ROM_LAT];

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .i_clk   (CLK_I),
    .i_rst_n (RST_N_I),
    .i_req   (REQ_I),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx)
  );

  assign GNT_O     = w_gnt;
  assign ROM_RST_O = ~RST_N_I;

  always_comb begin
    ROM_ADDR_O = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) ROM_ADDR_O = ADDR_I[k*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    w_any_tag = 1'b0;
    for (int unsigned s = 0; s < ROM_LAT; s++) begin
      w_any_tag = w_any_tag | r_tag[s].valid;
    end
  end

  // Keep the ROM clocked whenever a read is in flight so tags and data stay aligned.
  assign w_clk_en     = RST_N_I & ((|w_gnt) | w_any_tag);
  assign ROM_CLK_EN_O = w_clk_en;

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      for (int unsigned s = 0; s < ROM_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else if (w_clk_en) begin
      r_tag[0].valid <= |w_gnt;
      r_tag[0].idx   <= MAX_IDX_W'(w_gnt_idx);
      for (int unsigned s = 1; s < ROM_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign w_last = r_tag[ROM_LAT-1];

  always_comb begin
    RD_VALID_O = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      RD_VALID_O[k] = RST_N_I & w_last.valid & (w_last.idx == MAX_IDX_W'(k));
    end
  end

  assign RD_DATA_O = (|RD_VALID_O) ? ROM_Q_I : '0;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Directed bench for rom_rd_arbiter with a behavioural 2-stage ROM and a
// scoreboard of expected {requester, data} returns.
module tb_rom_rd_arbiter;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_REQ  = 2;

  logic                    CLK_I = 1'b0;
  logic                    RST_N_I;
  logic [N_REQ-1:0]        REQ_I;
  logic [N_REQ*ADDR_W-1:0] ADDR_I;
  logic [N_REQ-1:0]        GNT_O;
  logic [N_REQ-1:0]        RD_VALID_O;
  logic [DATA_W-1:0]       RD_DATA_O;
  logic [ADDR_W-1:0]       ROM_ADDR_O;
  logic                    ROM_CLK_EN_O;
  logic                    ROM_RST_O;
  logic [DATA_W-1:0]       ROM_Q_I;

  always #5 CLK_I = ~CLK_I;

  rom_rd_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .N_REQ   (N_REQ),
    .ROM_LAT (2)
  ) dut (
    .CLK_I        (CLK_I),
    .RST_N_I      (RST_N_I),
    .REQ_I        (REQ_I),
    .ADDR_I       (ADDR_I),
    .GNT_O        (GNT_O),
    .RD_VALID_O   (RD_VALID_O),
    .RD_DATA_O    (RD_DATA_O),
    .ROM_ADDR_O   (ROM_ADDR_O),
    .ROM_CLK_EN_O (ROM_CLK_EN_O),
    .ROM_RST_O    (ROM_RST_O),
    .ROM_Q_I      (ROM_Q_I)
  );

  // ROM: address register then output register, contents mem[a] = a[7:0] ^ A5.
  logic [ADDR_W-1:0] rom_a;
  logic [DATA_W-1:0] rom_q;
  always @(posedge CLK_I) begin
    if (ROM_RST_O) begin
      rom_a <= '0;
      rom_q <= '0;
    end else if (ROM_CLK_EN_O) begin
      rom_a <= ROM_ADDR_O;
      rom_q <= rom_a[7:0] ^ 8'hA5;
    end
  end
  assign ROM_Q_I = rom_q;

  typedef struct {
    logic [N_REQ-1:0]  vld;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [N_REQ-1:0] v, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.vld  = v;
    e.data = a[7:0] ^ 8'hA5;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK_I);
  endtask

  always @(negedge CLK_I) begin
    if (RD_VALID_O !== '0) begin
      if (sb.size() == 0) begin
        chk("rdv_unexpected", 32'(RD_VALID_O), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("rdv", 32'(RD_VALID_O), 32'(mon_e.vld));
        chk("rdata", 32'(RD_DATA_O), 32'(mon_e.data));
      end
    end
  end

  initial begin
    logic [N_REQ-1:0]  eg;
    logic [ADDR_W-1:0] ea;

    // 1. reset with both requesters asserting
    RST_N_I = 1'b0;
    REQ_I   = 2'b11;
    ADDR_I  = {14'h0002, 14'h0001};
    repeat (3) begin
      smp();
      chk("rst_gnt", 32'(GNT_O), 32'h0);
      chk("rst_rdv", 32'(RD_VALID_O), 32'h0);
      chk("rst_clken", 32'(ROM_CLK_EN_O), 32'h0);
      chk("rst_romrst", 32'(ROM_RST_O), 32'h1);
    end
    cyc();
    RST_N_I = 1'b1;
    REQ_I   = 2'b00;
    smp();
    chk("idle_gnt", 32'(GNT_O), 32'h0);
    chk("idle_clken", 32'(ROM_CLK_EN_O), 32'h0);
    chk("idle_romrst", 32'(ROM_RST_O), 32'h0);
    chk("idle_addr", 32'(ROM_ADDR_O), 32'h0);

    // 2. single read from requester 0
    cyc();
    REQ_I  = 2'b01;
    ADDR_I = {14'h0000, 14'h0010};
    smp();
    chk("single_gnt", 32'(GNT_O), 32'h1);
    chk("single_addr", 32'(ROM_ADDR_O), 32'h10);
    push(2'b01, 14'h0010);
    cyc();
    REQ_I = 2'b00;
    smp();
    chk("single_gnt_t1", 32'(GNT_O), 32'h0);
    chk("single_clken_t1", 32'(ROM_CLK_EN_O), 32'h1);
    cyc();
    smp();
    chk("single_clken_t2", 32'(ROM_CLK_EN_O), 32'h1);
    chk("single_rdv_t2", 32'(RD_VALID_O), 32'h1);
    cyc();
    smp();
    chk("single_clken_t3", 32'(ROM_CLK_EN_O), 32'h0);

    // 3. contention after a fresh reset: strict alternation starting at 0
    cyc();
    RST_N_I = 1'b0;
    smp();
    cyc();
    RST_N_I = 1'b1;
    REQ_I   = 2'b11;
    ADDR_I  = {14'h0002, 14'h0001};
    for (int i = 0; i < 4; i++) begin
      smp();
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      ea = eg[0] ? 14'h0001 : 14'h0002;
      chk("cont_gnt", 32'(GNT_O), 32'(eg));
      chk("cont_addr", 32'(ROM_ADDR_O), 32'(ea));
      push(eg, ea);
      cyc();
    end
    REQ_I = 2'b00;
    repeat (3) begin
      smp();
      cyc();
    end
    smp();
    chk("cont_drained_clken", 32'(ROM_CLK_EN_O), 32'h0);

    // 4. back-to-back reads from requester 1 at the top of the address space
    cyc();
    REQ_I = 2'b10;
    for (int i = 0; i < 4; i++) begin
      ea = 14'h3FFC + 14'(i);
      ADDR_I[ADDR_W +: ADDR_W] = ea;
      smp();
      chk("b2b_gnt", 32'(GNT_O), 32'h2);
      chk("b2b_addr", 32'(ROM_ADDR_O), 32'(ea));
      push(2'b10, ea);
      cyc();
    end
    REQ_I = 2'b00;
    repeat (3) begin
      smp();
      cyc();
    end

    // 5. reset while a read is in flight; pointer returns to favour requester 0
    REQ_I  = 2'b11;
    ADDR_I = {14'h0002, 14'h0001};
    smp();
    chk("mid_gnt_t0", 32'(GNT_O), 32'h1);
    cyc();
    RST_N_I = 1'b0;
    smp();
    chk("mid_gnt_rst", 32'(GNT_O), 32'h0);
    chk("mid_romrst", 32'(ROM_RST_O), 32'h1);
    cyc();
    RST_N_I = 1'b1;
    smp();
    chk("mid_rdv_dropped", 32'(RD_VALID_O), 32'h0);
    chk("mid_gnt_after", 32'(GNT_O), 32'h1);
    push(2'b01, 14'h0001);
    cyc();
    REQ_I = 2'b00;
    repeat (4) begin
      smp();
      cyc();
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
